// File: rtl/tx_link_ctrl_ml_if.sv
// Link-controller signal bundle: frame timing, SYNC~, configuration and lane/status outputs.
// master drives the controller inputs, slave is the controller itself.
interface tx_link_ctrl_ml_if #(
  parameter int NUM_LANES = 4
);
  logic                   frame_clk;
  logic                   lmfc_clk;
  logic                   i_sync_n;
  logic [7:0]             i_F;
  logic [7:0]             i_ila_multiframe_length;
  logic [NUM_LANES-1:0]   i_lane_en;
  logic [1:0]             i_test_mode;
  logic [4*NUM_LANES-1:0] o_link_mux;
  logic [1:0]             o_state;
  logic [7:0]             o_ila_mf_idx;
  logic                   o_ila_cfg_mf;
  logic [1:0]             o_test_sel;
  logic                   o_link_up;
  logic                   o_resync;
  logic                   o_err_report;
  logic [7:0]             o_err_cnt;

  modport master (
    output frame_clk, lmfc_clk, i_sync_n, i_F, i_ila_multiframe_length, i_lane_en, i_test_mode,
    input  o_link_mux, o_state, o_ila_mf_idx, o_ila_cfg_mf, o_test_sel, o_link_up, o_resync,
           o_err_report, o_err_cnt
  );

  modport slave (
    input  frame_clk, lmfc_clk, i_sync_n, i_F, i_ila_multiframe_length, i_lane_en, i_test_mode,
    output o_link_mux, o_state, o_ila_mf_idx, o_ila_cfg_mf, o_test_sel, o_link_up, o_resync,
           o_err_report, o_err_cnt
  );
endinterface

// File: rtl/tx_link_ctrl_ml.sv
// Transmit link controller: SYNC~ handshake, ILA sequencing, data/test lane selection,
// SYNC~ error reporting and resync handling for NUM_LANES lanes.
module tx_link_ctrl_ml #(
  parameter int NUM_LANES     = 4,
  parameter int RESYNC_FRAMES = 5
) (
  input logic              clk,
  input logic              rst_n,
  tx_link_ctrl_ml_if.slave link
);

  typedef enum logic [1:0] {
    ST_SYNC      = 2'd0,
    ST_INIT_LANE = 2'd1,
    ST_DATA_ENC  = 2'd2,
    ST_TEST      = 2'd3
  } state_e;

  localparam logic [3:0]             RESYNC_TH = 4'(RESYNC_FRAMES);
  localparam logic [4*NUM_LANES-1:0] MUX_RESET = {NUM_LANES{4'b0010}};

  state_e                 state, next_state;
  logic [3:0]             k_cnt, sync_cnt, kmin;
  logic [7:0]             ila_cnt, err_cnt;
  logic [8:0]             f_octets;
  logic                   test_active, resync_req, err_req, ila_done, sync_ok;
  logic [3:0]             lane_code;
  logic [4*NUM_LANES-1:0] mux_next, link_mux;
  logic                   link_up, resync_q, err_report_q;
  logic [1:0]             test_sel;

  assign f_octets = {1'b0, link.i_F} + 9'd1;

  // Minimum frames of K characters before the receiver may be handed ILA.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    kmin = 4'd2;
    if (f_octets == 9'd1)       kmin = 4'd10;
    else if (f_octets == 9'd2)  kmin = 4'd6;
    else if (f_octets <= 9'd4)  kmin = 4'd4;
    else if (f_octets <= 9'd8)  kmin = 4'd3;
  end

  assign test_active = (link.i_test_mode != 2'b00);
  assign sync_ok     = link.lmfc_clk && link.i_sync_n && (k_cnt >= kmin);
  assign ila_done    = link.lmfc_clk && (ila_cnt == link.i_ila_multiframe_length);
  // Test mode outranks a resync; a resync outranks ILA completion.
  assign resync_req  = ((state == ST_INIT_LANE) || (state == ST_DATA_ENC)) &&
                       (sync_cnt >= RESYNC_TH) && !test_active;
  // A short SYNC~ low pulse ends the clk i_sync_n returns high while sync_cnt still holds its length.
  assign err_req     = (state == ST_DATA_ENC) && link.i_sync_n &&
                       (sync_cnt != 4'd0) && (sync_cnt < RESYNC_TH);

  // NOTE: asynchronous active-low reset; all sequential state uses non-blocking assignments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_SYNC;
    else        state <= next_state;
  end

  always_comb begin
    next_state = ST_SYNC;
    if (test_active) begin
      next_state = ST_TEST;
    end else begin
      case (state)
        ST_SYNC:      next_state = sync_ok ? ST_INIT_LANE : ST_SYNC;
        ST_INIT_LANE: begin
          if (resync_req)    next_state = ST_SYNC;
          else if (ila_done) next_state = ST_DATA_ENC;
          else               next_state = ST_INIT_LANE;
        end
        ST_DATA_ENC:  next_state = resync_req ? ST_SYNC : ST_DATA_ENC;
        default:      next_state = ST_SYNC;
      endcase
    end
  end

  always_comb begin
    lane_code = 4'b0010;
    case (state)
      ST_INIT_LANE: lane_code = 4'b0100;
      ST_DATA_ENC:  lane_code = 4'b0001;
      ST_TEST:      lane_code = 4'b1000;
      default:      lane_code = 4'b0010;
    endcase
  end

  always_comb begin
    mux_next = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (link.i_lane_en[i]) mux_next[4*i +: 4] = lane_code;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_cnt        <= '0;
      ila_cnt      <= '0;
      sync_cnt     <= '0;
      err_cnt      <= '0;
      resync_q     <= 1'b0;
      err_report_q <= 1'b0;
      link_mux     <= MUX_RESET;
      link_up      <= 1'b0;
      test_sel     <= '0;
    end else begin
      if (state != ST_SYNC)                          k_cnt <= '0;
      else if (link.frame_clk && (k_cnt != 4'hF))    k_cnt <= k_cnt + 4'd1;

      // Multiframe 0 begins on the strobe that enters INIT_LANE, so the count starts there at 0.
      if ((state != ST_INIT_LANE) || (next_state != ST_INIT_LANE)) ila_cnt <= '0;
      else if (link.lmfc_clk)                                      ila_cnt <= ila_cnt + 8'd1;

      if (link.i_sync_n)                                sync_cnt <= '0;
      else if (link.frame_clk && (sync_cnt != 4'hF))    sync_cnt <= sync_cnt + 4'd1;

      if (err_req && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;

      resync_q     <= resync_req;
      err_report_q <= err_req;
      link_mux     <= mux_next;
      link_up      <= (state == ST_DATA_ENC);
      test_sel     <= (state == ST_TEST) ? link.i_test_mode : 2'b00;
    end
  end

  assign link.o_state      = state;
  assign link.o_ila_mf_idx = (state == ST_INIT_LANE) ? ila_cnt : 8'd0;
  assign link.o_ila_cfg_mf = (state == ST_INIT_LANE) && (ila_cnt == 8'd1);
  assign link.o_link_mux   = link_mux;
  assign link.o_link_up    = link_up;
  assign link.o_test_sel   = test_sel;
  assign link.o_resync     = resync_q;
  assign link.o_err_report = err_report_q;
  assign link.o_err_cnt    = err_cnt;

endmodule

// File: tb/tb_tx_link_ctrl_ml.sv
// Bench for tx_link_ctrl_ml: directed scenarios plus a randomized run, all checked against
// a behavioural model of the link rules kept here.
module tb_tx_link_ctrl_ml;
  localparam int NL = 4;
  localparam int RF = 5;
  localparam logic [4*NL-1:0] MUX_SYNC = {NL{4'b0010}};
  localparam logic [4*NL-1:0] MUX_ILA  = {NL{4'b0100}};
  localparam logic [4*NL-1:0] MUX_DATA = {NL{4'b0001}};
  localparam logic [4*NL-1:0] MUX_TEST = {NL{4'b1000}};

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int n_vec = 0;
  int n_bad = 0;
  int tick = 0, fp = 2, mf_frames = 32, entry_tick = 0;

  // Behavioural model: state as 0..3 (SYNC, INIT_LANE, DATA_ENC, TEST), counters as plain ints.
  int m_state, m_k, m_ila, m_sync, m_errs, m_tsel;
  bit m_up, m_resync, m_err;
  logic [4*NL-1:0] m_mux;

  always #5 clk = ~clk;

  tx_link_ctrl_ml_if #(.NUM_LANES(NL)) tif ();
  tx_link_ctrl_ml #(.NUM_LANES(NL), .RESYNC_FRAMES(RF)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .link (tif.slave)
  );

  function automatic int kmin_of(int f);
    if (f == 1) return 10;
    if (f == 2) return 6;
    if (f <= 4) return 4;
    if (f <= 8) return 3;
    return 2;
  endfunction

  function automatic logic [3:0] lane_code(int st);
    case (st)
      1:       return 4'b0100;
      2:       return 4'b0001;
      3:       return 4'b1000;
      default: return 4'b0010;
    endcase
  endfunction

  task automatic model_reset();
    m_state = 0; m_k = 0; m_ila = 0; m_sync = 0; m_errs = 0; m_tsel = 0;
    m_up = 0; m_resync = 0; m_err = 0; m_mux = MUX_SYNC;
  endtask

  // One device clock of the link rules, using the inputs present at the edge.
  task automatic model_step();
    int ns;
    bit sn, fr, lm, tm;
    sn = tif.i_sync_n; fr = tif.frame_clk; lm = tif.lmfc_clk; tm = (tif.i_test_mode != 0);
    m_resync = (m_state == 1 || m_state == 2) && m_sync >= RF && !tm;
    m_err    = (m_state == 2) && sn && m_sync >= 1 && m_sync < RF;
    if (tm)                ns = 3;
    else if (m_resync)     ns = 0;
    else if (m_state == 0) ns = (lm && sn && m_k >= kmin_of(int'(tif.i_F) + 1)) ? 1 : 0;
    else if (m_state == 1) ns = (lm && m_ila == int'(tif.i_ila_multiframe_length)) ? 2 : 1;
    else if (m_state == 2) ns = 2;
    else                   ns = 0;
    m_up   = (m_state == 2);
    m_tsel = (m_state == 3) ? int'(tif.i_test_mode) : 0;
    for (int l = 0; l < NL; l++) m_mux[4*l +: 4] = tif.i_lane_en[l] ? lane_code(m_state) : 4'b0000;
    m_k    = (m_state == 0) ? ((m_k + fr > 15) ? 15 : m_k + fr) : 0;
    m_ila  = (m_state == 1 && ns == 1) ? (m_ila + lm) % 256 : 0;
    m_sync = sn ? 0 : ((m_sync + fr > 15) ? 15 : m_sync + fr);
    if (m_err && m_errs < 255) m_errs++;
    m_state = ns;
  endtask

  // Drive this clk's strobes, let the edge happen, update the model, sample 1 ns later.
  task automatic advance();
    tif.frame_clk = ((tick % fp) == 0);
    tif.lmfc_clk  = tif.frame_clk && (((tick / fp) % mf_frames) == 0);
    @(posedge clk);
    model_step();
    #1;
    tick++;
  endtask

  task automatic test_reset();
    tif.frame_clk = 0; tif.lmfc_clk = 0; tif.i_sync_n = 1; tif.i_F = 8'd0;
    tif.i_ila_multiframe_length = 8'd3; tif.i_lane_en = 4'b0101; tif.i_test_mode = 2'd0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (tif.o_state !== 2'd0) begin n_bad++; $display("FAIL reset.state: got %0d expected 0", tif.o_state); end
    n_vec++; if (tif.o_link_mux !== MUX_SYNC) begin n_bad++; $display("FAIL reset.mux: got %h expected %h", tif.o_link_mux, MUX_SYNC); end
    n_vec++; if (tif.o_link_up !== 1'b0) begin n_bad++; $display("FAIL reset.link_up: got %b expected 0", tif.o_link_up); end
    n_vec++; if (tif.o_resync !== 1'b0) begin n_bad++; $display("FAIL reset.resync: got %b expected 0", tif.o_resync); end
    n_vec++; if (tif.o_err_report !== 1'b0) begin n_bad++; $display("FAIL reset.err_report: got %b expected 0", tif.o_err_report); end
    n_vec++; if (tif.o_test_sel !== 2'd0) begin n_bad++; $display("FAIL reset.test_sel: got %0d expected 0", tif.o_test_sel); end
    n_vec++; if (tif.o_ila_cfg_mf !== 1'b0) begin n_bad++; $display("FAIL reset.cfg_mf: got %b expected 0", tif.o_ila_cfg_mf); end
    n_vec++; if (tif.o_err_cnt !== 8'd0) begin n_bad++; $display("FAIL reset.err_cnt: got %0d expected 0", tif.o_err_cnt); end
    rst_n = 1'b1;
    model_reset();
    tif.i_lane_en = 4'hF;
  endtask

  task automatic test_sync_exit();
    bit entered = 0;
    int exp_entry = 0;
    fp = 2; mf_frames = 32; tick = 0;
    // First multiframe boundary by which at least kmin(F=1) frame strobes have been seen.
    while (exp_entry / fp < kmin_of(1)) exp_entry += fp * mf_frames;
    for (int c = 0; c < 300 && !entered; c++) begin
      advance();
      n_vec++; if (tif.o_state !== 2'(m_state)) begin n_bad++; $display("FAIL sync_exit.state: got %0d expected %0d", tif.o_state, m_state); end
      n_vec++; if (tif.o_link_mux !== m_mux) begin n_bad++; $display("FAIL sync_exit.mux: got %h expected %h", tif.o_link_mux, m_mux); end
      if (tif.o_state == 2'd1) begin entered = 1; entry_tick = tick - 1; end
    end
    n_vec++; if (!entered) begin n_bad++; $display("FAIL sync_exit.timeout: got no INIT_LANE, expected entry at clk %0d", exp_entry); end
    n_vec++; if (entry_tick != exp_entry) begin n_bad++; $display("FAIL sync_exit.entry_clk: got %0d expected %0d", entry_tick, exp_entry); end
    advance();
    n_vec++; if (tif.o_link_mux !== MUX_ILA) begin n_bad++; $display("FAIL sync_exit.ila_mux: got %h expected %h", tif.o_link_mux, MUX_ILA); end
  endtask

  task automatic test_ila();
    bit left = 0;
    int cfg_clks = 0, dwell;
    for (int c = 0; c < 600 && !left; c++) begin
      advance();
      n_vec++; if (tif.o_state !== 2'(m_state)) begin n_bad++; $display("FAIL ila.state: got %0d expected %0d", tif.o_state, m_state); end
      n_vec++; if (tif.o_ila_mf_idx !== 8'((m_state == 1) ? m_ila : 0)) begin n_bad++; $display("FAIL ila.mf_idx: got %0d expected %0d", tif.o_ila_mf_idx, (m_state == 1) ? m_ila : 0); end
      n_vec++; if (tif.o_ila_cfg_mf !== (m_state == 1 && m_ila == 1)) begin n_bad++; $display("FAIL ila.cfg_mf: got %b expected %b", tif.o_ila_cfg_mf, (m_state == 1 && m_ila == 1)); end
      if (tif.o_ila_cfg_mf === 1'b1) cfg_clks++;
      if (tif.o_state == 2'd2) left = 1;
    end
    dwell = (tick - 1) - entry_tick;
    n_vec++; if (dwell != 4 * fp * mf_frames) begin n_bad++; $display("FAIL ila.length: got %0d clks expected %0d", dwell, 4 * fp * mf_frames); end
    n_vec++; if (cfg_clks != fp * mf_frames) begin n_bad++; $display("FAIL ila.cfg_clks: got %0d expected %0d", cfg_clks, fp * mf_frames); end
    advance();
    n_vec++; if (tif.o_link_mux !== MUX_DATA) begin n_bad++; $display("FAIL ila.data_mux: got %h expected %h", tif.o_link_mux, MUX_DATA); end
    n_vec++; if (tif.o_link_up !== 1'b1) begin n_bad++; $display("FAIL ila.link_up: got %b expected 1", tif.o_link_up); end
  endtask

  task automatic test_err_report();
    int pulses = 0;
    for (int c = 0; c < 2 * fp + 6; c++) begin
      tif.i_sync_n = (c >= 2 * fp);
      advance();
      n_vec++; if (tif.o_err_report !== m_err) begin n_bad++; $display("FAIL err.report: got %b expected %b", tif.o_err_report, m_err); end
      n_vec++; if (tif.o_err_cnt !== 8'(m_errs)) begin n_bad++; $display("FAIL err.cnt: got %0d expected %0d", tif.o_err_cnt, m_errs); end
      if (tif.o_err_report === 1'b1) pulses++;
    end
    n_vec++; if (pulses != 1) begin n_bad++; $display("FAIL err.pulses: got %0d expected 1", pulses); end
    n_vec++; if (tif.o_err_cnt !== 8'd1) begin n_bad++; $display("FAIL err.final_cnt: got %0d expected 1", tif.o_err_cnt); end
    n_vec++; if (tif.o_state !== 2'd2) begin n_bad++; $display("FAIL err.state: got %0d expected 2", tif.o_state); end
  endtask

  task automatic test_resync();
    int pulses = 0;
    bit chk_next = 0;
    for (int c = 0; c < RF * fp + 6; c++) begin
      tif.i_sync_n = (c >= RF * fp + 2);
      advance();
      n_vec++; if (tif.o_state !== 2'(m_state)) begin n_bad++; $display("FAIL resync.state: got %0d expected %0d", tif.o_state, m_state); end
      n_vec++; if (tif.o_resync !== m_resync) begin n_bad++; $display("FAIL resync.pulse: got %b expected %b", tif.o_resync, m_resync); end
      if (chk_next) begin
        n_vec++; if (tif.o_link_mux !== MUX_SYNC) begin n_bad++; $display("FAIL resync.mux: got %h expected %h", tif.o_link_mux, MUX_SYNC); end
        chk_next = 0;
      end
      if (tif.o_resync === 1'b1) begin
        pulses++; chk_next = 1;
        n_vec++; if (tif.o_state !== 2'd0) begin n_bad++; $display("FAIL resync.to_sync: got %0d expected 0", tif.o_state); end
      end
    end
    n_vec++; if (pulses != 1) begin n_bad++; $display("FAIL resync.pulses: got %0d expected 1", pulses); end
  endtask

  task automatic test_mode();
    bit entered = 0;
    for (int c = 0; c < 400 && !entered; c++) begin
      advance();
      if (tif.o_state == 2'd1) entered = 1;
    end
    n_vec++; if (!entered) begin n_bad++; $display("FAIL mode.reach_ila: got state %0d expected 1", tif.o_state); end
    tif.i_test_mode = 2'd2;
    advance();
    n_vec++; if (tif.o_state !== 2'd3) begin n_bad++; $display("FAIL mode.enter: got %0d expected 3", tif.o_state); end
    advance();
    n_vec++; if (tif.o_link_mux !== MUX_TEST) begin n_bad++; $display("FAIL mode.mux: got %h expected %h", tif.o_link_mux, MUX_TEST); end
    n_vec++; if (tif.o_test_sel !== 2'd2) begin n_bad++; $display("FAIL mode.test_sel: got %0d expected 2", tif.o_test_sel); end
    tif.i_test_mode = 2'd0;
    advance();
    n_vec++; if (tif.o_state !== 2'd0) begin n_bad++; $display("FAIL mode.exit: got %0d expected 0", tif.o_state); end
    advance();
    n_vec++; if (tif.o_link_mux !== MUX_SYNC) begin n_bad++; $display("FAIL mode.sync_mux: got %h expected %h", tif.o_link_mux, MUX_SYNC); end
    n_vec++; if (tif.o_test_sel !== 2'd0) begin n_bad++; $display("FAIL mode.test_sel_clr: got %0d expected 0", tif.o_test_sel); end
  endtask

  task automatic test_lane_sat();
    bit in_data = 0;
    int pulses = 0;
    tif.i_lane_en = 4'b0101; tif.i_ila_multiframe_length = 8'd0; mf_frames = 4;
    for (int c = 0; c < 400 && !in_data; c++) begin
      advance();
      if (tif.o_state == 2'd2) in_data = 1;
    end
    n_vec++; if (!in_data) begin n_bad++; $display("FAIL lanes.reach_data: got state %0d expected 2", tif.o_state); end
    for (int r = 0; r < 300; r++) begin
      for (int c = 0; c <= fp; c++) begin
        tif.i_sync_n = (c == fp);
        advance();
        n_vec++; if (tif.o_err_cnt !== 8'(m_errs)) begin n_bad++; $display("FAIL lanes.err_cnt: got %0d expected %0d", tif.o_err_cnt, m_errs); end
        if (tif.o_err_report === 1'b1) pulses++;
      end
    end
    n_vec++; if (pulses != 300) begin n_bad++; $display("FAIL lanes.pulses: got %0d expected 300", pulses); end
    n_vec++; if (tif.o_err_cnt !== 8'd255) begin n_bad++; $display("FAIL lanes.saturate: got %0d expected 255", tif.o_err_cnt); end
    n_vec++; if (tif.o_link_mux !== 16'h0101) begin n_bad++; $display("FAIL lanes.mux: got %h expected 0101", tif.o_link_mux); end
    n_vec++; if (tif.o_state !== 2'd2) begin n_bad++; $display("FAIL lanes.state: got %0d expected 2", tif.o_state); end
  endtask

  task automatic test_reset_async();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_vec++; if (tif.o_state !== 2'd0) begin n_bad++; $display("FAIL areset.state: got %0d expected 0", tif.o_state); end
    n_vec++; if (tif.o_link_mux !== MUX_SYNC) begin n_bad++; $display("FAIL areset.mux: got %h expected %h", tif.o_link_mux, MUX_SYNC); end
    n_vec++; if (tif.o_link_up !== 1'b0) begin n_bad++; $display("FAIL areset.link_up: got %b expected 0", tif.o_link_up); end
    n_vec++; if (tif.o_err_cnt !== 8'd0) begin n_bad++; $display("FAIL areset.err_cnt: got %0d expected 0", tif.o_err_cnt); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    repeat (5) begin
      advance();
      n_vec++; if (tif.o_state !== 2'(m_state)) begin n_bad++; $display("FAIL areset.restart: got %0d expected %0d", tif.o_state, m_state); end
      n_vec++; if (tif.o_link_mux !== m_mux) begin n_bad++; $display("FAIL areset.restart_mux: got %h expected %h", tif.o_link_mux, m_mux); end
    end
  endtask

  task automatic test_random();
    fp = $urandom_range(2, 3); mf_frames = $urandom_range(2, 6); tif.i_lane_en = 4'hF;
    for (int c = 0; c < 4000; c++) begin
      if (m_state == 0 && $urandom_range(0, 49) == 0) begin
        tif.i_F = 8'($urandom_range(0, 15));
        tif.i_ila_multiframe_length = 8'($urandom_range(0, 3));
        tif.i_lane_en = 4'($urandom_range(0, 15));
      end
      if (tif.i_sync_n) tif.i_sync_n = ($urandom_range(0, 29) != 0);
      else              tif.i_sync_n = ($urandom_range(0, 5) == 0);
      if (tif.i_test_mode == 0) begin
        if ($urandom_range(0, 399) == 0) tif.i_test_mode = 2'($urandom_range(1, 3));
      end else if ($urandom_range(0, 14) == 0) tif.i_test_mode = 2'd0;
      advance();
      n_vec++; if (tif.o_state !== 2'(m_state)) begin n_bad++; $display("FAIL rand.state @%0d: got %0d expected %0d", tick, tif.o_state, m_state); end
      n_vec++; if (tif.o_link_mux !== m_mux) begin n_bad++; $display("FAIL rand.mux @%0d: got %h expected %h", tick, tif.o_link_mux, m_mux); end
      n_vec++; if (tif.o_link_up !== m_up) begin n_bad++; $display("FAIL rand.link_up @%0d: got %b expected %b", tick, tif.o_link_up, m_up); end
      n_vec++; if (tif.o_resync !== m_resync) begin n_bad++; $display("FAIL rand.resync @%0d: got %b expected %b", tick, tif.o_resync, m_resync); end
      n_vec++; if (tif.o_err_report !== m_err) begin n_bad++; $display("FAIL rand.err_report @%0d: got %b expected %b", tick, tif.o_err_report, m_err); end
      n_vec++; if (tif.o_err_cnt !== 8'(m_errs)) begin n_bad++; $display("FAIL rand.err_cnt @%0d: got %0d expected %0d", tick, tif.o_err_cnt, m_errs); end
      n_vec++; if (tif.o_test_sel !== 2'(m_tsel)) begin n_bad++; $display("FAIL rand.test_sel @%0d: got %0d expected %0d", tick, tif.o_test_sel, m_tsel); end
      n_vec++; if (tif.o_ila_mf_idx !== 8'((m_state == 1) ? m_ila : 0)) begin n_bad++; $display("FAIL rand.mf_idx @%0d: got %0d expected %0d", tick, tif.o_ila_mf_idx, (m_state == 1) ? m_ila : 0); end
      n_vec++; if (tif.o_ila_cfg_mf !== (m_state == 1 && m_ila == 1)) begin n_bad++; $display("FAIL rand.cfg_mf @%0d: got %b expected %b", tick, tif.o_ila_cfg_mf, (m_state == 1 && m_ila == 1)); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, expected finish within 2 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_sync_exit();
    test_ila();
    test_err_report();
    test_resync();
    test_mode();
    test_lane_sat();
    test_reset_async();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
